// File: rtl/sample_buffer_reader.sv
`default_nettype none
// ============================================================================
// Module      : sample_buffer_reader
// Description : Bursts sequential reads from a synchronous RAM and streams the
//               samples out through a 2-entry valid/ready FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_buffer_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_start_addr,
    input  logic [ADDR_WIDTH:0]   i_length,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_read  = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] c_addr_one  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   c_depth     = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_len_one   = (ADDR_WIDTH + 1)'(1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_fifo [0:1];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;

    logic                  w_pop;
    logic                  w_push;
    logic [2:0]            w_occupancy;
    logic                  w_issue;
    logic                  w_accept;
    logic [ADDR_WIDTH:0]   w_len_clamped;

    assign w_pop         = o_valid & i_ready;
    assign w_push        = r_inflight;
    // Slots already claimed once this edge's pop is accounted for; at most
    // two samples may ever be buffered or on their way from the RAM.
    assign w_occupancy   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue       = (r_state == c_st_read) && (r_remaining != '0) && (w_occupancy < 3'd2);
    assign w_accept      = (r_state == c_st_idle) && i_start;
    assign w_len_clamped = (i_length > c_depth) ? c_depth : i_length;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (i_start) begin
                    w_state_next = (i_length == '0) ? c_st_done : c_st_read;
                end
            end
            c_st_read: begin
                if (w_issue && (r_remaining == c_len_one)) begin
                    w_state_next = c_st_drain;
                end
            end
            c_st_drain: begin
                if ((r_count == 2'd0) && !r_inflight) begin
                    w_state_next = c_st_done;
                end
            end
            c_st_done: begin
                w_state_next = c_st_idle;
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_addr   <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            r_inflight <= w_issue;
            if (w_accept && (i_length != '0)) begin
                r_rd_addr   <= i_start_addr;
                r_remaining <= w_len_clamped;
            end else if (w_issue) begin
                r_rd_addr   <= (r_rd_addr == c_last_addr) ? '0 : r_rd_addr + c_addr_one;
                r_remaining <= r_remaining - c_len_one;
            end
            // RAM data for the read issued on the previous edge lands now.
            if (w_push) begin
                r_fifo[r_wr_ptr] <= i_rd_data;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_rd_addr = r_rd_addr;
    assign o_data    = r_fifo[r_rd_ptr];
    assign o_valid   = (r_count != 2'd0);
    assign o_busy    = (r_state != c_st_idle);
    assign o_done    = (r_state == c_st_done);

endmodule
`default_nettype wire

// File: tb/tb_sample_buffer_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_buffer_reader
// Description : Table-driven scoreboard bench for sample_buffer_reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_buffer_reader;

    typedef struct {
        logic [7:0] start_addr;
        logic [8:0] length;
        int         mode;    // 0: ready high, 1: ready 1,0,0 pattern, 2: ready high + stray start
        int         exp_n;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] start_addr;
    logic [8:0] length;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       busy;
    logic       done;

    logic [7:0] mem [0:255];
    logic [7:0] exp_q [$];
    vec_t       vecs [7];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rx_cnt, done_cnt, done_cyc, valid_seen, first_valid_cyc, last_xfer_cyc, start_cyc;
    logic       hold_pending = 1'b0;
    logic [7:0] held;

    always #5 clk = ~clk;

    sample_buffer_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(256)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_start_addr(start_addr),
        .i_length(length), .o_rd_addr(rd_addr), .i_rd_data(rd_data), .o_data(data),
        .o_valid(valid), .i_ready(ready), .o_busy(busy), .o_done(done)
    );

    always @(posedge clk) rd_data <= mem[rd_addr];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Monitor: scoreboard pop on every transfer, hold-stability under backpressure.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (valid) begin
                valid_seen++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (hold_pending) begin
                check("hold_valid", int'(valid), 1);
                check("hold_data", int'(data), int'(held));
            end
            hold_pending = valid && !ready;
            held = data;
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sample: got 0x%0h, expected no sample", data);
                end else begin
                    check("sample", int'(data), int'(exp_q.pop_front()));
                end
                rx_cnt++;
                last_xfer_cyc = cyc;
            end
        end
    end

    function automatic logic ready_for(input int mode, input int t);
        return (mode == 1) ? ((t % 3) == 0) : 1'b1;
    endfunction

    task automatic clear_counters();
        rx_cnt = 0; done_cnt = 0; done_cyc = -1; valid_seen = 0;
        first_valid_cyc = -1; last_xfer_cyc = -1;
    endtask

    // Called at posedge+1; i_start is driven immediately so the next edge accepts it.
    task automatic run_burst(input logic [7:0] sa, input logic [8:0] len, input int mode, input int exp_n);
        bit ok = 0;
        clear_counters();
        for (int i = 0; i < exp_n; i++) exp_q.push_back(8'(int'(sa) + i));
        start = 1'b1; start_addr = sa; length = len; ready = ready_for(mode, 0);
        @(posedge clk); #1;
        start_cyc = cyc;
        start = 1'b0;
        for (int t = 1; t < 1000; t++) begin
            if (done_cnt > 0 && !busy) begin
                ok = 1;
                break;
            end
            ready = ready_for(mode, t);
            start = (mode == 2 && t == 3);
            if (mode == 2 && t == 3) begin
                start_addr = 8'h80; length = 9'd5;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; ready = 1'b1;
        check("burst_terminated", int'(ok), 1);
        repeat (3) begin @(posedge clk); #1; end
        check("rx_count", rx_cnt, exp_n);
        check("done_pulses", done_cnt, 1);
        check("queue_empty", exp_q.size(), 0);
        check("busy_after", int'(busy), 0);
        if (exp_n > 0) begin
            check("first_valid_latency", first_valid_cyc - start_cyc, 3);
            if (mode != 1) check("throughput", last_xfer_cyc - first_valid_cyc, exp_n - 1);
        end else begin
            check("no_valid", valid_seen, 0);
            check("done_latency_ok", int'((done_cyc - start_cyc) >= 1 && (done_cyc - start_cyc) <= 2), 1);
        end
        exp_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_addr"}, int'(rd_addr), 0);
        check({tag, "_valid"}, int'(valid), 0);
        check({tag, "_data"}, int'(data), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        for (int k = 0; k < 256; k++) mem[k] = 8'(k);
        vecs[0] = '{start_addr: 8'h10, length: 9'd4,   mode: 0, exp_n: 4};
        vecs[1] = '{start_addr: 8'hFE, length: 9'd4,   mode: 0, exp_n: 4};
        vecs[2] = '{start_addr: 8'h20, length: 9'd8,   mode: 1, exp_n: 8};
        vecs[3] = '{start_addr: 8'h33, length: 9'd0,   mode: 0, exp_n: 0};
        vecs[4] = '{start_addr: 8'h05, length: 9'd300, mode: 0, exp_n: 256};
        vecs[5] = '{start_addr: 8'h30, length: 9'd6,   mode: 2, exp_n: 6};
        vecs[6] = '{start_addr: 8'hF0, length: 9'd5,   mode: 1, exp_n: 5};

        rst_n = 1'b1; start = 1'b0; start_addr = '0; length = '0; ready = 1'b1;
        clear_counters();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // First vector starts in the same step as reset release.
        foreach (vecs[i]) run_burst(vecs[i].start_addr, vecs[i].length, vecs[i].mode, vecs[i].exp_n);

        // Reset in the middle of a 10-sample burst.
        clear_counters();
        for (int i = 0; i < 10; i++) exp_q.push_back(8'(8'h60 + i));
        start = 1'b1; start_addr = 8'h60; length = 9'd10; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ok = 0;
        for (int t = 0; t < 50; t++) begin
            if (rx_cnt >= 3) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check("midburst_three_samples", int'(ok), 1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        valid_seen = 0;
        repeat (5) begin @(posedge clk); #1; end
        check("post_reset_no_valid", valid_seen, 0);
        check("post_reset_idle", int'(busy), 0);
        run_burst(8'h40, 9'd2, 0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
